fb_write_sched: RTL and testbench
=================================

# fb_write_sched

Framebuffer write scheduler. Shares the single display-memory write port (16-bit data, active-low write strobe) between several drawing requesters (snake body, food, clear engine). Writes are only admitted while the display scan is outside the visible lines. The block also produces the per-frame and game-step timing pulses derived from the scan line counter. It sits between the drawing engines and the top-level memory tristate.

## Interface
- `N_REQ`, default 3: number of requesters, legal range 2..4.
- `ADDR_W`, default 17: memory address width.
- `DATA_W`, default 16: memory data width.
- `VISIBLE_LINES`, default 240: scan lines 0..VISIBLE_LINES-1 are visible; lines at or above this value form the write window.
- `FRAME_DIV`, default 60: number of frames per game step.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous, active-low.
- `y` in 9: current scan line from display timing.
- `req` in N_REQ: per-requester write request, level; held until granted.
- `req_addr` in N_REQ*ADDR_W: packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_data` in N_REQ*DATA_W: packed write data, same packing scheme.
- `gnt` out N_REQ: one-hot, one-cycle pulse; the addr/data of the granted requester have been captured.
- `mem_addr` out ADDR_W: memory address.
- `mem_dq` out DATA_W: write data. The top level tristates it with `mem_dq_oe`.
- `mem_dq_oe` out 1: data drive enable.
- `w_en` out 1: active-low memory write strobe.
- `frame_tick` out 1: one-cycle pulse when the write window opens.
- `step_tick` out 1: one-cycle pulse on every FRAME_DIV-th `frame_tick`.

## Operation
- `in_win` = (`y` >= VISIBLE_LINES), combinational.
- `in_win_d` is `in_win` registered.
- `frame_tick` is registered and pulses on the cycle after `in_win` & ~`in_win_d` is true.
- `in_win_d` resets to 1. Consequently, coming out of reset during blanking produces no tick.
- Frame counter:
  - Range 0..FRAME_DIV-1. Increments on every `frame_tick`.
  - A `frame_tick` taken while the counter equals FRAME_DIV-1 wraps the counter to 0 and asserts `step_tick` in the same cycle as `frame_tick`.
- Write FSM states: ARB, SETUP, STROBE, HOLD.
  - **ARB**: if `in_win` is true and any `req` is set, pick a requester by round-robin, capture its addr/data into registers, and go to SETUP. Otherwise stay in ARB.
  - **SETUP**: `gnt[i]`=1, `mem_dq_oe`=1, `w_en`=1, `mem_addr`/`mem_dq` valid. Go to STROBE.
  - **STROBE**: `w_en`=0, `mem_dq_oe`=1, addr/data stable. Go to HOLD.
  - **HOLD**: `w_en`=1, `mem_dq_oe`=1, addr/data stable. Go to ARB.
- Round-robin pointer:
  - Search starts at `ptr` and ascends modulo N_REQ. The first set `req` wins.
  - After granting i, `ptr` = (i+1) mod N_REQ.
  - `ptr` resets to 0.
- Window closing (`in_win` falls) while the FSM is in SETUP, STROBE or HOLD: the current write completes unmodified. No new grant is issued until the window reopens.
- `req` deasserted before its grant: no write occurs and there is no error.
- Addr/data are captured only in ARB. Input changes after the capture edge have no effect on the write in flight.
- `mem_addr` and `mem_dq` hold their last captured values outside a write.
- Reset values:
  - `gnt`=0, `mem_dq_oe`=0, `w_en`=1, `frame_tick`=0, `step_tick`=0.
  - `mem_addr`=0, `mem_dq`=0.
  - FSM=ARB, frame counter=0.

## Timing
- All outputs are registered.
- The requester must hold `req`/addr/data through the cycle in which `gnt` is high. It may change them from the next cycle.
- Latency: `req` seen in ARB at edge k → `gnt` high in cycle k+1. `w_en` low in cycle k+2. Port released (`mem_dq_oe`=0) in cycle k+4, unless a back-to-back grant follows.
- Throughput: one write per 4 cycles. `mem_dq_oe` stays 0 during the ARB cycle between writes.
- Reset mid-write: on the edge where `rst`=0 the write aborts. `w_en`=1 and `mem_dq_oe`=0 take effect from the next cycle.
- `frame_tick` lags the entry of `y` into the window by exactly 1 cycle.

## Test plan
- **Reset**: hold `rst`=0 for 2 cycles with `y`=250 and `req`=3'b111. Required: `w_en`=1, `mem_dq_oe`=0, `gnt`=0, `frame_tick`=0; no tick after release.
- **Single write**: `y`=250, `req`=3'b010, addr 0x00A0A, data 0xFFFF. Required: `gnt`=3'b010 for exactly 1 cycle; next cycle `w_en`=0 with `mem_addr`=0x00A0A and `mem_dq`=0xFFFF; `mem_dq_oe` high for 3 cycles.
- **Round-robin**: all three `req` held in the window. Required: grants in order 0,1,2,0,1, spaced 4 cycles apart; with `req`=3'b101, order is 0,2,0.
- **Window gating**: `y`=100 with `req[0]`=1 gives no `gnt` for 20 cycles. Step `y` to 240. Required: `frame_tick` pulses once, and `gnt[0]` occurs within 2 cycles of the step.
- **Window close mid-write**: set `y`=0 during STROBE. Required: the write completes (HOLD with `w_en`=1) and there is no further `gnt` while `y`<240.
- **Step divider**: FRAME_DIV=4, 9 visible→blank transitions. Required: 9 `frame_tick` pulses; `step_tick` coincides with ticks 4 and 8 only.

Source files
------------

// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler.
// Arbitrates several drawing requesters onto the single display-memory write
// port, admitting writes only while the scan line is outside the visible area.
// It also derives the per-frame and per-game-step pulses from the scan line.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   y                current scan line
//   req              per-requester level request, held until granted
//   req_addr         packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data         packed request data, same packing
//   gnt              one-hot grant pulse; the addr/data have been captured
//   mem_addr, mem_dq memory address / write data (hold last write outside a write)
//   mem_dq_oe        data drive enable for the top-level tristate
//   w_en             active-low memory write strobe
//   frame_tick       one-cycle pulse when the write window opens
//   step_tick        one-cycle pulse on every FRAME_DIV-th frame_tick
module fb_write_sched #(
    parameter int unsigned N_REQ         = 3,
    parameter int unsigned ADDR_W        = 17,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned VISIBLE_LINES = 240,
    parameter int unsigned FRAME_DIV     = 60
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [8:0]                y,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_dq,
    output logic                      mem_dq_oe,
    output logic                      w_en,
    output logic                      frame_tick,
    output logic                      step_tick
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [PTR_W-1:0] LAST_REQ   = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   pick, cand;
    logic               found;
    logic [N_REQ-1:0]   gnt_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic               oe_nxt;
    logic               wen_nxt;

    logic               in_win, in_win_d, win_rise;
    logic [CNT_W-1:0]   frame_cnt;

    logic [ADDR_W-1:0]  addr_arr [N_REQ];
    logic [DATA_W-1:0]  data_arr [N_REQ];

    // Unpack the flat request buses into per-requester views.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign in_win   = (y >= 9'(VISIBLE_LINES));
    assign win_rise = in_win & ~in_win_d;

    // Round-robin search: first set request at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = PTR_W'((32'(ptr) + off) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = '0;
        addr_nxt  = mem_addr;
        data_nxt  = mem_dq;
        oe_nxt    = 1'b0;
        wen_nxt   = 1'b1;
        case (state)
            ARB: begin
                if (in_win && found) begin
                    state_nxt = SETUP;
                    ptr_nxt   = (pick == LAST_REQ) ? '0 : pick + PTR_W'(1);
                    gnt_nxt   = N_REQ'(1) << pick;
                    addr_nxt  = addr_arr[pick];
                    data_nxt  = data_arr[pick];
                    oe_nxt    = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = STROBE;
                oe_nxt    = 1'b1;
                wen_nxt   = 1'b0;
            end
            STROBE: begin
                state_nxt = HOLD;
                oe_nxt    = 1'b1;
            end
            HOLD: begin
                // Returning to ARB releases the port for at least one cycle.
                state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    // Write FSM state and registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ARB;
            ptr       <= '0;
            gnt       <= '0;
            mem_addr  <= '0;
            mem_dq    <= '0;
            mem_dq_oe <= 1'b0;
            w_en      <= 1'b1;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            mem_addr  <= addr_nxt;
            mem_dq    <= data_nxt;
            mem_dq_oe <= oe_nxt;
            w_en      <= wen_nxt;
        end
    end

    // Frame and step pulses; in_win_d resets high so leaving reset in blanking
    // does not look like a window opening.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_win_d   <= 1'b1;
            frame_tick <= 1'b0;
            step_tick  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            in_win_d   <= in_win;
            frame_tick <= win_rise;
            step_tick  <= win_rise && (frame_cnt == LAST_FRAME);
            if (win_rise) begin
                frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_write_sched.sv
// Self-checking bench for fb_write_sched (FRAME_DIV overridden to 4).
// Every cycle the outputs are compared against a transaction-level reference
// model; directed table records and hand sequences add targeted checks.
module tb_fb_write_sched;

    localparam int unsigned N   = 3;
    localparam int unsigned AW  = 17;
    localparam int unsigned DW  = 16;
    localparam int unsigned VIS = 240;
    localparam int unsigned FD  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b0;
    logic [8:0]     y   = '0;
    logic [N-1:0]   req = '0;
    logic [AW-1:0]  a_in [N];
    logic [DW-1:0]  d_in [N];
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;

    logic [N-1:0]   gnt;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_dq;
    logic           mem_dq_oe, w_en, frame_tick, step_tick;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_addr[i*AW +: AW] = a_in[i];
        assign req_data[i*DW +: DW] = d_in[i];
    end

    fb_write_sched #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .VISIBLE_LINES(VIS), .FRAME_DIV(FD)
    ) dut (
        .clk(clk), .rst(rst), .y(y), .req(req),
        .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .mem_addr(mem_addr), .mem_dq(mem_dq), .mem_dq_oe(mem_dq_oe),
        .w_en(w_en), .frame_tick(frame_tick), .step_tick(step_tick)
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: a write is described only by the edge it started on;
    // every port value follows from the age of that write.
    longint         cyc     = 0;
    longint         start   = -10;
    int             ptr     = 0;
    int             gidx    = 0;
    int             nticks  = 0;
    bit             win_d   = 1'b1;
    logic [AW-1:0]  m_addr  = '0;
    logic [DW-1:0]  m_data  = '0;
    logic [N-1:0]   e_gnt;
    logic           e_oe, e_wen, e_ft, e_st;

    task automatic tick();
        logic           r;
        logic [8:0]     yy;
        logic [N-1:0]   rq;
        logic [AW-1:0]  aa [N];
        logic [DW-1:0]  dd [N];
        bit             win;
        longint         age;
        r = rst; yy = y; rq = req; aa = a_in; dd = d_in;
        @(posedge clk);
        #1;
        if (!r) begin
            start = -10; ptr = 0; nticks = 0; win_d = 1'b1;
            m_addr = '0; m_data = '0;
            e_ft = 1'b0; e_st = 1'b0;
        end else begin
            win   = (yy >= 9'(VIS));
            e_ft  = win && !win_d;
            win_d = win;
            if (e_ft) nticks++;
            e_st = e_ft && (nticks % FD == 0);
            if (cyc - start >= 4 && win && rq != 0) begin
                for (int o = 0; o < N; o++) begin
                    int i;
                    i = (ptr + o) % N;
                    if (rq[i]) begin
                        gidx = i; start = cyc; ptr = (i + 1) % N;
                        m_addr = aa[i]; m_data = dd[i];
                        break;
                    end
                end
            end
        end
        age   = cyc - start;
        e_gnt = (age == 0) ? N'(1 << gidx) : '0;
        e_oe  = (age <= 2);
        e_wen = (age != 1);
        check($sformatf("model_cyc%0d", cyc),
              {gnt, mem_addr, mem_dq, mem_dq_oe, w_en, frame_tick, step_tick},
              {e_gnt, m_addr, m_data, e_oe, e_wen, e_ft, e_st});
        cyc++;
    endtask

    task automatic do_reset(logic [8:0] yv);
        rst = 1'b0; req = '0; y = yv;
        tick(); tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic [8:0]    y;
        logic [N-1:0]  req;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [N-1:0]  exp_gnt;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } rec_t;

    rec_t tbl [8];

    // Requester i drives addr a + i*0x100 and data d - i.
    task automatic apply_rec(rec_t r, int k);
        int seen;
        y = r.y; req = r.req;
        for (int i = 0; i < N; i++) begin
            a_in[i] = r.a + AW'(i * 256);
            d_in[i] = r.d - DW'(i);
        end
        if (r.exp_gnt != 0) begin
            tick();
            check($sformatf("rec%0d_gnt", k), 64'(gnt), 64'(r.exp_gnt));
            req = '0;
            tick();
            check($sformatf("rec%0d_strobe", k), 64'(w_en), 64'(0));
            check($sformatf("rec%0d_addr", k), 64'(mem_addr), 64'(r.exp_addr));
            check($sformatf("rec%0d_data", k), 64'(mem_dq), 64'(r.exp_data));
            tick();
            check($sformatf("rec%0d_hold", k), 64'({mem_dq_oe, w_en}), 64'(2'b11));
            tick();
            check($sformatf("rec%0d_release", k), 64'(mem_dq_oe), 64'(0));
        end else begin
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (gnt != 0) seen++;
            end
            check($sformatf("rec%0d_nogrant", k), 64'(seen), 64'(0));
            check($sformatf("rec%0d_addr_held", k), 64'(mem_addr), 64'(r.exp_addr));
            check($sformatf("rec%0d_data_held", k), 64'(mem_dq), 64'(r.exp_data));
        end
    endtask

    // Hold a request pattern and check grant order (2-bit fields, LSB first) and spacing.
    task automatic rr_run(string nm, logic [N-1:0] pat, int n, logic [9:0] order);
        int         got;
        longint     last;
        logic [N-1:0] e;
        got = 0; last = 0;
        y = 9'd250; req = pat;
        for (int c = 0; c < 40 && got < n; c++) begin
            tick();
            if (gnt != 0) begin
                e = N'(1) << order[2*got +: 2];
                check($sformatf("%s_gnt%0d", nm, got), 64'(gnt), 64'(e));
                if (got > 0) check($sformatf("%s_space%0d", nm, got), 64'(cyc - last), 64'(4));
                last = cyc;
                got++;
            end
        end
        check($sformatf("%s_count", nm), 64'(got), 64'(n));
        req = '0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nft, nst, stmask, seen, sel;
        logic [8:0] ylist [7];

        for (int i = 0; i < N; i++) begin a_in[i] = '0; d_in[i] = '0; end

        tbl[0] = '{9'd250, 3'b010, 17'h0090A, 16'h0000, 3'b010, 17'h00A0A, 16'hFFFF};
        tbl[1] = '{9'd250, 3'b111, 17'h1F000, 16'h1234, 3'b100, 17'h1F200, 16'h1232};
        tbl[2] = '{9'd300, 3'b111, 17'h00000, 16'hABCD, 3'b001, 17'h00000, 16'hABCD};
        tbl[3] = '{9'd511, 3'b101, 17'h12345, 16'h8000, 3'b100, 17'h12545, 16'h7FFE};
        tbl[4] = '{9'd240, 3'b101, 17'h00100, 16'h5555, 3'b001, 17'h00100, 16'h5555};
        tbl[5] = '{9'd250, 3'b011, 17'h1FFFF, 16'h0001, 3'b010, 17'h000FF, 16'h0000};
        tbl[6] = '{9'd245, 3'b001, 17'h0AAAA, 16'hF0F0, 3'b001, 17'h0AAAA, 16'hF0F0};
        tbl[7] = '{9'd100, 3'b001, 17'h01234, 16'h4321, 3'b000, 17'h0AAAA, 16'hF0F0};

        // Reset held in the window with every requester asking.
        rst = 1'b0; y = 9'd250; req = 3'b111;
        tick(); tick();
        check("reset_w_en", 64'(w_en), 64'(1));
        check("reset_oe", 64'(mem_dq_oe), 64'(0));
        check("reset_gnt", 64'(gnt), 64'(0));
        check("reset_frame_tick", 64'(frame_tick), 64'(0));
        check("reset_addr", 64'(mem_addr), 64'(0));
        rst = 1'b1; req = '0;
        nft = 0;
        for (int c = 0; c < 3; c++) begin tick(); if (frame_tick) nft++; end
        check("reset_no_tick", 64'(nft), 64'(0));

        for (int k = 0; k < 8; k++) apply_rec(tbl[k], k);

        // Window opens with requester 0 waiting.
        y = 9'd240; req = 3'b001;
        tick();
        check("gate_frame_tick", 64'(frame_tick), 64'(1));
        check("gate_gnt", 64'(gnt), 64'(3'b001));
        req = '0;
        nft = 0;
        for (int c = 0; c < 3; c++) begin tick(); if (frame_tick) nft++; end
        check("gate_tick_once", 64'(nft), 64'(0));

        // Window closes during the strobe cycle.
        y = 9'd250; req = 3'b010;
        tick();
        check("close_gnt", 64'(gnt), 64'(3'b010));
        tick();
        check("close_strobe", 64'(w_en), 64'(0));
        y = 9'd0;
        tick();
        check("close_hold", 64'({mem_dq_oe, w_en}), 64'(2'b11));
        tick();
        check("close_release", 64'(mem_dq_oe), 64'(0));
        seen = 0;
        for (int c = 0; c < 10; c++) begin tick(); if (gnt != 0) seen++; end
        check("close_no_grant", 64'(seen), 64'(0));
        req = '0;

        do_reset(9'd250);
        rr_run("rr_all", 3'b111, 5, 10'b01_00_10_01_00);
        do_reset(9'd250);
        rr_run("rr_101", 3'b101, 3, 10'b00_00_00_10_00);

        // Nine visible-to-blank transitions with FRAME_DIV=4.
        do_reset(9'd0);
        nft = 0; nst = 0; stmask = 0;
        for (int t = 0; t < 9; t++) begin
            y = 9'd0;
            tick(); tick();
            y = 9'd250;
            for (int c = 0; c < 3; c++) begin
                tick();
                if (frame_tick) nft++;
                if (step_tick) begin nst++; stmask |= (1 << nft); end
            end
        end
        check("div_ticks", 64'(nft), 64'(9));
        check("div_steps", 64'(nst), 64'(2));
        check("div_step_pos", 64'(stmask), 64'((1 << 4) | (1 << 8)));

        // Randomized traffic with occasional resets.
        ylist = '{9'd0, 9'd100, 9'd239, 9'd240, 9'd241, 9'd300, 9'd511};
        do_reset(9'd250);
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) begin
                sel = int'($urandom_range(0, 6));
                y = ylist[sel];
            end
            if ($urandom_range(0, 2) == 0) req = N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                a_in[i] = AW'($urandom());
                d_in[i] = DW'($urandom());
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
